ex_unit: RTL and testbench

- Execute stage of the 5-stage pipeline. Consumes the decoded operand, immediate, register-destination and control fields held in the ID/EX pipeline register.
- Resolves ALU control from ALUOp and funct, selects operands and the destination register, and registers the result and the surviving control signals toward the MEM stage.
- Adds an iterative 32-cycle multiplier that raises a stall to hold the ID/EX register upstream.

---
 rtl/ex_unit.sv | 204 ++++++++++++++++++++
 tb/tb_ex_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_unit.sv
// Execute stage: ALU control decode, operand/destination select, EX/MEM register,
// plus an iterative shift-add multiplier that stalls the ID/EX register while busy.
module ex_unit #(
    parameter int         MUL_CYCLES = 32,
    parameter logic [5:0] FUNCT_MULT = 6'h18
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] data_a_in,
    input  logic [31:0] data_b_in,
    input  logic [31:0] sign_extend_in,
    input  logic [4:0]  reg_dest_r_type_in,
    input  logic [4:0]  reg_dest_l_type_in,
    input  logic        RegDst_in,
    input  logic        ALUSrc_in,
    input  logic        MemToReg_in,
    input  logic        RegWrite_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        Branch_in,
    input  logic [1:0]  ALUOp_in,
    output logic        stall,
    output logic [31:0] alu_result_out,
    output logic [31:0] store_data_out,
    output logic [4:0]  reg_dest_out,
    output logic        zero_out,
    output logic        MemToReg_out,
    output logic        RegWrite_out,
    output logic        MemRead_out,
    output logic        MemWrite_out,
    output logic        Branch_out
);

    localparam int                DATA_W   = 32;
    localparam int                CNT_W    = $clog2(MUL_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q;

    // Stage p0: decode and single-cycle ALU on the ID/EX register contents
    logic [5:0]               funct_p0;
    logic [4:0]               shamt_p0;
    logic signed [DATA_W-1:0] opa_p0, opb_p0, shb_p0;
    logic [4:0]               dest_p0;
    logic [DATA_W-1:0]        alu_res_p0;
    logic                     alu_ok_p0;
    logic                     is_mult_p0;

    assign funct_p0   = sign_extend_in[5:0];
    assign shamt_p0   = sign_extend_in[10:6];
    assign opa_p0     = data_a_in;
    assign opb_p0     = ALUSrc_in ? sign_extend_in : data_b_in;
    assign shb_p0     = data_b_in;
    assign dest_p0    = RegDst_in ? reg_dest_r_type_in : reg_dest_l_type_in;
    assign is_mult_p0 = (ALUOp_in == 2'b10) && (funct_p0 == FUNCT_MULT);

    always_comb begin
        alu_res_p0 = '0;
        alu_ok_p0  = 1'b1;
        case (ALUOp_in)
            2'b00: alu_res_p0 = $unsigned(opa_p0 + opb_p0);
            2'b01: alu_res_p0 = $unsigned(opa_p0 - opb_p0);
            2'b11: alu_res_p0 = $unsigned(opa_p0) | {16'h0000, sign_extend_in[15:0]};
            default: begin
                case (funct_p0)
                    6'h20, 6'h21: alu_res_p0 = $unsigned(opa_p0 + opb_p0);
                    6'h22, 6'h23: alu_res_p0 = $unsigned(opa_p0 - opb_p0);
                    6'h24: alu_res_p0 = $unsigned(opa_p0 & opb_p0);
                    6'h25: alu_res_p0 = $unsigned(opa_p0 | opb_p0);
                    6'h26: alu_res_p0 = $unsigned(opa_p0 ^ opb_p0);
                    6'h27: alu_res_p0 = $unsigned(~(opa_p0 | opb_p0));
                    6'h2A: alu_res_p0 = {{(DATA_W-1){1'b0}}, (opa_p0 < opb_p0)};
                    6'h2B: alu_res_p0 = {{(DATA_W-1){1'b0}},
                                         ($unsigned(opa_p0) < $unsigned(opb_p0))};
                    6'h00: alu_res_p0 = $unsigned(shb_p0 <<< shamt_p0);
                    6'h02: alu_res_p0 = $unsigned(shb_p0) >> shamt_p0;
                    6'h03: alu_res_p0 = $unsigned(shb_p0 >>> shamt_p0);
                    FUNCT_MULT: alu_res_p0 = '0;
                    default: alu_ok_p0 = 1'b0;
                endcase
            end
        endcase
    end

    // Stage p1: multiplier state, operands latched when the multiply starts
    logic [DATA_W-1:0] mul_a_p1, mul_b_p1, acc_p1, acc_step_p1;
    logic [DATA_W-1:0] mul_store_p1;
    logic [4:0]        mul_dest_p1;
    logic [4:0]        mul_ctl_p1;
    logic              start_p1;

    assign acc_step_p1 = acc_p1 + (mul_b_p1[0] ? mul_a_p1 : '0);
    assign start_p1    = (state_q == IDLE) && is_mult_p0 && !flush;

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_mult_p0) begin
                    state_d = MUL;
                    stall   = 1'b1;
                end
            end
            MUL: begin
                if (count_q == CNT_LAST) state_d = IDLE;
                else                     stall   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            stall   = 1'b0;
        end
        if (reset) stall = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == MUL && state_d == MUL) count_q <= count_q + CNT_W'(1);
            else                                  count_q <= '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mul_a_p1     <= '0;
            mul_b_p1     <= '0;
            acc_p1       <= '0;
            mul_store_p1 <= '0;
            mul_dest_p1  <= '0;
            mul_ctl_p1   <= '0;
        end else if (start_p1) begin
            mul_a_p1     <= data_a_in;
            mul_b_p1     <= data_b_in;
            acc_p1       <= '0;
            mul_store_p1 <= data_b_in;
            mul_dest_p1  <= dest_p0;
            mul_ctl_p1   <= {MemToReg_in, RegWrite_in, MemRead_in, MemWrite_in, Branch_in};
        end else if (state_q == MUL) begin
            acc_p1   <= acc_step_p1;
            mul_a_p1 <= mul_a_p1 << 1;
            mul_b_p1 <= mul_b_p1 >> 1;
        end
    end

    // Stage p2: EX/MEM register; anything not selected below is a bubble
    logic [DATA_W-1:0] res_d, store_d;
    logic [4:0]        dest_d;
    logic [4:0]        ctl_d;
    logic              zero_d;

    always_comb begin
        res_d   = '0;
        store_d = '0;
        dest_d  = '0;
        ctl_d   = '0;
        zero_d  = 1'b0;
        if (!flush) begin
            if (state_q == IDLE && !is_mult_p0) begin
                res_d   = alu_res_p0;
                store_d = data_b_in;
                dest_d  = dest_p0;
                zero_d  = (alu_res_p0 == '0);
                ctl_d   = {MemToReg_in, RegWrite_in & alu_ok_p0, MemRead_in,
                           MemWrite_in, Branch_in};
            end else if (state_q == MUL && count_q == CNT_LAST) begin
                res_d   = acc_step_p1;
                store_d = mul_store_p1;
                dest_d  = mul_dest_p1;
                zero_d  = (acc_step_p1 == '0);
                ctl_d   = mul_ctl_p1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alu_result_out <= '0;
            store_data_out <= '0;
            reg_dest_out   <= '0;
            zero_out       <= 1'b0;
            {MemToReg_out, RegWrite_out, MemRead_out, MemWrite_out, Branch_out} <= '0;
        end else begin
            alu_result_out <= res_d;
            store_data_out <= store_d;
            reg_dest_out   <= dest_d;
            zero_out       <= zero_d;
            {MemToReg_out, RegWrite_out, MemRead_out, MemWrite_out, Branch_out} <= ctl_d;
        end
    end

endmodule

// File: tb/tb_ex_unit.sv
// Directed-vector bench for ex_unit: ALU ops, operand/dest selection, multiply
// stall timing, flush/reset aborts and unknown-funct handling.
module tb_ex_unit;

    logic        clock = 1'b0;
    logic        reset, flush;
    logic [31:0] data_a_in, data_b_in, sign_extend_in;
    logic [4:0]  reg_dest_r_type_in, reg_dest_l_type_in;
    logic        RegDst_in, ALUSrc_in, MemToReg_in, RegWrite_in;
    logic        MemRead_in, MemWrite_in, Branch_in;
    logic [1:0]  ALUOp_in;
    logic        stall;
    logic [31:0] alu_result_out, store_data_out;
    logic [4:0]  reg_dest_out;
    logic        zero_out, MemToReg_out, RegWrite_out, MemRead_out, MemWrite_out, Branch_out;

    int n_vec = 0;
    int n_err = 0;

    ex_unit dut (
        .clock(clock), .reset(reset), .flush(flush),
        .data_a_in(data_a_in), .data_b_in(data_b_in), .sign_extend_in(sign_extend_in),
        .reg_dest_r_type_in(reg_dest_r_type_in), .reg_dest_l_type_in(reg_dest_l_type_in),
        .RegDst_in(RegDst_in), .ALUSrc_in(ALUSrc_in), .MemToReg_in(MemToReg_in),
        .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .Branch_in(Branch_in), .ALUOp_in(ALUOp_in), .stall(stall),
        .alu_result_out(alu_result_out), .store_data_out(store_data_out),
        .reg_dest_out(reg_dest_out), .zero_out(zero_out), .MemToReg_out(MemToReg_out),
        .RegWrite_out(RegWrite_out), .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out),
        .Branch_out(Branch_out)
    );

    always #5 clock = ~clock;

    task automatic set_nop();
        flush = 0; data_a_in = 0; data_b_in = 0; sign_extend_in = 0;
        reg_dest_r_type_in = 0; reg_dest_l_type_in = 0;
        RegDst_in = 0; ALUSrc_in = 0; MemToReg_in = 0; RegWrite_in = 0;
        MemRead_in = 0; MemWrite_in = 0; Branch_in = 0; ALUOp_in = 2'b00;
    endtask

    task automatic set_r(input logic [5:0] funct, input logic [4:0] shamt,
                         input logic [31:0] a, input logic [31:0] b);
        set_nop();
        ALUOp_in = 2'b10; RegDst_in = 1; RegWrite_in = 1;
        sign_extend_in = {21'b0, shamt, funct};
        data_a_in = a; data_b_in = b;
    endtask

    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        set_r(6'h20, 0, 32'd40, 32'd2);
        reg_dest_r_type_in = 5'd7;
        step();
        #2 reset = 1;
        #1;
        n_vec++; if (alu_result_out !== 32'd0) begin n_err++; $display("FAIL reset_result got %h want 0", alu_result_out); end
        n_vec++; if (reg_dest_out !== 5'd0 || RegWrite_out !== 1'b0 || store_data_out !== 32'd0)
            begin n_err++; $display("FAIL reset_ctl got dest=%0d rw=%b sd=%h want 0", reg_dest_out, RegWrite_out, store_data_out); end
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", stall); end
        @(negedge clock);
        reset = 0;
        set_nop();
    endtask

    task automatic test_add();
        @(negedge clock);
        set_r(6'h20, 0, 32'd5, 32'd7);
        reg_dest_r_type_in = 5'd3; reg_dest_l_type_in = 5'd4;
        #1;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL add_stall got %b want 0", stall); end
        step();
        n_vec++; if (alu_result_out !== 32'd12) begin n_err++; $display("FAIL add_result got %h want 0000000c", alu_result_out); end
        n_vec++; if (reg_dest_out !== 5'd3) begin n_err++; $display("FAIL add_dest got %0d want 3", reg_dest_out); end
        n_vec++; if (RegWrite_out !== 1'b1 || zero_out !== 1'b0) begin n_err++; $display("FAIL add_flags got rw=%b z=%b want 1 0", RegWrite_out, zero_out); end
        n_vec++; if (store_data_out !== 32'd7) begin n_err++; $display("FAIL add_store got %h want 7", store_data_out); end
    endtask

    task automatic test_compare();
        @(negedge clock);
        set_nop();
        ALUOp_in = 2'b01; data_a_in = 32'hDEADBEEF; data_b_in = 32'hDEADBEEF; Branch_in = 1;
        step();
        n_vec++; if (alu_result_out !== 32'd0 || zero_out !== 1'b1 || Branch_out !== 1'b1)
            begin n_err++; $display("FAIL beq got r=%h z=%b br=%b want 0 1 1", alu_result_out, zero_out, Branch_out); end
        @(negedge clock);
        set_r(6'h2A, 0, 32'hFFFFFFFF, 32'd1);
        step();
        n_vec++; if (alu_result_out !== 32'd1) begin n_err++; $display("FAIL slt got %h want 1", alu_result_out); end
        @(negedge clock);
        set_r(6'h2B, 0, 32'hFFFFFFFF, 32'd1);
        step();
        n_vec++; if (alu_result_out !== 32'd0 || zero_out !== 1'b1) begin n_err++; $display("FAIL sltu got %h z=%b want 0 1", alu_result_out, zero_out); end
    endtask

    task automatic test_alu_mix();
        logic [5:0]  fn  [10] = '{6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h00, 6'h02, 6'h03, 6'h21, 6'h00};
        logic [4:0]  sh  [10] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd4, 5'd4, 5'd0, 5'd4};
        logic        src [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] va  [10] = '{32'd5, 32'hF0F0, 32'hF0F0, 32'hFF, 32'd0, 32'h12345678,
                                  32'h12345678, 32'h12345678, 32'hFFFFFFFF, 32'h12345678};
        logic [31:0] vb  [10] = '{32'd7, 32'hFF00, 32'h0F00, 32'h0F, 32'd0, 32'd1,
                                  32'h80000000, 32'h80000000, 32'd1, 32'd3};
        logic [31:0] ex  [10] = '{32'hFFFFFFFE, 32'hF000, 32'hFFF0, 32'hF0, 32'hFFFFFFFF, 32'h10,
                                  32'h08000000, 32'hF8000000, 32'd0, 32'h30};
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            set_r(fn[i], sh[i], va[i], vb[i]);
            ALUSrc_in = src[i];
            step();
            n_vec++; if (alu_result_out !== ex[i]) begin n_err++; $display("FAIL alu_mix[%0d] funct=%h got %h want %h", i, fn[i], alu_result_out, ex[i]); end
        end
        @(negedge clock);
        set_nop();
        ALUOp_in = 2'b11; ALUSrc_in = 1; data_a_in = 32'hF0000000; sign_extend_in = 32'hFFFF8001;
        step();
        n_vec++; if (alu_result_out !== 32'hF0008001) begin n_err++; $display("FAIL ori got %h want f0008001", alu_result_out); end
    endtask

    task automatic test_load();
        @(negedge clock);
        set_nop();
        ALUSrc_in = 1; ALUOp_in = 2'b00; data_a_in = 32'd100; data_b_in = 32'h55;
        sign_extend_in = 32'hFFFFFFFC; MemRead_in = 1; MemToReg_in = 1; RegWrite_in = 1;
        RegDst_in = 0; reg_dest_l_type_in = 5'd9; reg_dest_r_type_in = 5'd31;
        step();
        n_vec++; if (alu_result_out !== 32'd96) begin n_err++; $display("FAIL load_addr got %h want 00000060", alu_result_out); end
        n_vec++; if (reg_dest_out !== 5'd9 || MemRead_out !== 1'b1 || MemToReg_out !== 1'b1)
            begin n_err++; $display("FAIL load_ctl got dest=%0d mr=%b m2r=%b want 9 1 1", reg_dest_out, MemRead_out, MemToReg_out); end
    endtask

    task automatic test_mult(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int stall_cyc = 0;
        int bad = 0;
        @(negedge clock);
        set_r(6'h18, 0, a, b);
        reg_dest_r_type_in = 5'd5;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!stall) break;
            stall_cyc++;
            if (i > 0 && (RegWrite_out || MemRead_out || MemWrite_out || Branch_out || zero_out ||
                          alu_result_out != 0 || reg_dest_out != 0)) bad++;
            @(negedge clock);
        end
        n_vec++; if (stall_cyc !== 32) begin n_err++; $display("FAIL mult_stall_cycles got %0d want 32", stall_cyc); end
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL mult_bubble got %0d non-bubble cycles want 0", bad); end
        step();
        n_vec++; if (alu_result_out !== exp) begin n_err++; $display("FAIL mult_result got %h want %h", alu_result_out, exp); end
        n_vec++; if (RegWrite_out !== 1'b1 || reg_dest_out !== 5'd5)
            begin n_err++; $display("FAIL mult_ctl got rw=%b dest=%0d want 1 5", RegWrite_out, reg_dest_out); end
        @(negedge clock);
        set_nop();
    endtask

    task automatic test_flush();
        int late = 0;
        @(negedge clock);
        set_r(6'h20, 0, 32'd5, 32'd7);
        flush = 1;
        step();
        n_vec++; if (alu_result_out !== 32'd0 || RegWrite_out !== 1'b0)
            begin n_err++; $display("FAIL flush_add got r=%h rw=%b want 0 0", alu_result_out, RegWrite_out); end
        @(negedge clock);
        set_r(6'h18, 0, 32'd9, 32'd9);
        repeat (11) @(posedge clock);
        @(negedge clock);
        flush = 1;
        #1;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL flush_stall got %b want 0", stall); end
        step();
        n_vec++; if (RegWrite_out !== 1'b0 || alu_result_out !== 32'd0)
            begin n_err++; $display("FAIL flush_bubble got rw=%b r=%h want 0 0", RegWrite_out, alu_result_out); end
        @(negedge clock);
        set_nop();
        for (int i = 0; i < 30; i++) begin
            step();
            if (RegWrite_out || alu_result_out != 0 || stall) late++;
        end
        n_vec++; if (late !== 0) begin n_err++; $display("FAIL flush_late got %0d bad cycles want 0", late); end
    endtask

    task automatic test_reset_mult();
        int late = 0;
        @(negedge clock);
        set_r(6'h18, 0, 32'd3, 32'd5);
        repeat (21) @(posedge clock);
        #2 reset = 1;
        #1;
        n_vec++; if (stall !== 1'b0 || RegWrite_out !== 1'b0 || alu_result_out !== 32'd0)
            begin n_err++; $display("FAIL rst_mult got st=%b rw=%b r=%h want 0 0 0", stall, RegWrite_out, alu_result_out); end
        @(negedge clock);
        set_nop();
        reset = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (RegWrite_out || alu_result_out != 0 || stall) late++;
        end
        n_vec++; if (late !== 0) begin n_err++; $display("FAIL rst_mult_late got %0d bad cycles want 0", late); end
    endtask

    task automatic test_unknown();
        @(negedge clock);
        set_r(6'h3F, 0, 32'd5, 32'd7);
        step();
        n_vec++; if (RegWrite_out !== 1'b0 || alu_result_out !== 32'd0)
            begin n_err++; $display("FAIL unknown_funct got rw=%b r=%h want 0 0", RegWrite_out, alu_result_out); end
    endtask

    task automatic test_back_to_back();
        @(negedge clock);
        set_r(6'h20, 0, 32'd1000, 32'd24);
        reg_dest_r_type_in = 5'd12;
        step();
        n_vec++; if (alu_result_out !== 32'd1024 || reg_dest_out !== 5'd12)
            begin n_err++; $display("FAIL b2b_add got r=%h d=%0d want 400 12", alu_result_out, reg_dest_out); end
        @(negedge clock);
        set_r(6'h23, 0, 32'd3, 32'd10);
        reg_dest_r_type_in = 5'd13;
        step();
        n_vec++; if (alu_result_out !== 32'hFFFFFFF9 || reg_dest_out !== 5'd13)
            begin n_err++; $display("FAIL b2b_sub got r=%h d=%0d want fffffff9 13", alu_result_out, reg_dest_out); end
        @(negedge clock);
        set_nop();
        MemWrite_in = 1; data_a_in = 32'h1000; data_b_in = 32'hCAFEF00D; ALUSrc_in = 1; sign_extend_in = 32'd8;
        step();
        n_vec++; if (alu_result_out !== 32'h1008 || store_data_out !== 32'hCAFEF00D || MemWrite_out !== 1'b1)
            begin n_err++; $display("FAIL b2b_store got r=%h sd=%h mw=%b want 1008 cafef00d 1", alu_result_out, store_data_out, MemWrite_out); end
    endtask

    initial begin
        reset = 0;
        set_nop();
        #1 reset = 1;
        #1;
        n_vec++; if (alu_result_out !== 32'd0 || RegWrite_out !== 1'b0 || stall !== 1'b0)
            begin n_err++; $display("FAIL init_reset got r=%h rw=%b st=%b want 0 0 0", alu_result_out, RegWrite_out, stall); end
        repeat (2) @(negedge clock);
        reset = 0;
        test_reset();
        test_add();
        test_compare();
        test_alu_mix();
        test_load();
        test_mult(32'h00012345, 32'h00000100, 32'h01234500);
        test_mult(32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB);
        test_flush();
        test_reset_mult();
        test_unknown();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
